// File: rtl/count_sched_pkg.sv
// Shared state encoding and width helper for the count_sched scheduler slice.
package count_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bits needed to hold an index below n, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_sched_sat_counter.sv
// Saturating up-counter shared by all requesters; clear has priority over enable.
module sat_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  logic [CW-1:0] cnt_d, cnt_q;

  assign cnt    = cnt_q;
  assign at_max = &cnt_q;

  // Holds at all-ones instead of wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler that lends one saturating pulse counter to NREQ requesters,
// sequencing clear/count/done for the current owner and aborting on drop or timeout.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CW   = 4,
  parameter int TMO  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              x,
  output logic [NREQ-1:0]              gnt,
  output logic                         busy,
  output logic [CW-1:0]                cnt,
  output logic                         done,
  output logic                         abort,
  output logic [clog2_min1(NREQ)-1:0]  owner_id
);

  localparam int IDW = clog2_min1(NREQ);
  localparam int TW  = $clog2(TMO + 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_gnt_q, last_gnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  int              rr_idx;
  logic            own_x, own_req;
  logic            abort_evt;
  logic            cnt_clr, cnt_en, cnt_at_max;

  sat_counter #(.CW(CW)) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (cnt),
    .at_max (cnt_at_max)
  );

  assign own_x    = x[owner_q];
  assign own_req  = req[owner_q];
  assign gnt      = gnt_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign abort    = abort_q;
  assign owner_id = owner_q;

  // Scan downward so the requester nearest after last_gnt is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    rr_idx     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      rr_idx = (int'(last_gnt_q) + i) % NREQ;
      if (req[rr_idx[IDW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = rr_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      last_gnt_q <= IDW'(NREQ - 1);
      gnt_q      <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      tmo_q      <= tmo_d;
    end
  end

  // Reaching terminal count outranks a simultaneous request drop or timeout.
  always_comb begin
    state_d   = state_q;
    abort_evt = 1'b0;
    case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_CLEAR;
      S_CLEAR: state_d = S_COUNT;
      S_COUNT: begin
        if (own_x && cnt_at_max) begin
          state_d = S_DONE;
        end else if (!own_req) begin
          abort_evt = 1'b1;
          state_d   = S_IDLE;
        end else if (!own_x && (tmo_q == TW'(TMO - 1))) begin
          abort_evt = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    done_d     = 1'b0;
    abort_d    = abort_evt;
    tmo_d      = tmo_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d        = pick_id;
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
        end
      end
      S_CLEAR: begin
        cnt_clr = 1'b1;
        tmo_d   = '0;
      end
      S_COUNT: begin
        if (state_d == S_DONE) begin
          done_d     = 1'b1;
          gnt_d      = '0;
          last_gnt_d = owner_q;
        end else if (abort_evt) begin
          gnt_d      = '0;
          last_gnt_d = owner_q;
        end else if (own_x) begin
          cnt_en = 1'b1;
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_count_sched.sv
// Scoreboard bench for count_sched: stimulus queues expected grant/done/abort events
// with their cycle numbers, and a negedge monitor pops and compares them.
module tb_count_sched;

  localparam int NREQ    = 2;
  localparam int CW      = 4;
  localparam int TMO     = 8;
  localparam int K_GNT   = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int kind;
    int id;
    int cnt;
    int cyc;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] x = '0;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [CW-1:0]   cnt;
  logic            done;
  logic            abort;
  logic [0:0]      owner_id;

  int              n_total = 0;
  int              n_bad = 0;
  int              cyc = 0;
  ev_t             sb[$];
  ev_t             mon_e;
  int              act_kind;
  logic [NREQ-1:0] prev_gnt = '0;

  count_sched #(.NREQ(NREQ), .CW(CW), .TMO(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .x        (x),
    .gnt      (gnt),
    .busy     (busy),
    .cnt      (cnt),
    .done     (done),
    .abort    (abort),
    .owner_id (owner_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] xv, input int n);
    req = r;
    x   = xv;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectEvent(input int kind, input int id, input int c, input int at_cyc);
    sb.push_back('{kind, id, c, at_cyc});
  endtask

  task automatic resetDut();
    req   = '0;
    x     = '0;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Any grant rise, done or abort must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if (done || abort || (gnt != '0 && prev_gnt == '0)) begin
        checkOutput("event_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e    = sb.pop_front();
          act_kind = done ? K_DONE : (abort ? K_ABORT : K_GNT);
          checkOutput("event_kind", act_kind, mon_e.kind);
          checkOutput("event_cycle", cyc, mon_e.cyc);
          checkOutput("owner_id", int'(owner_id), mon_e.id);
          if (mon_e.kind == K_GNT) begin
            checkOutput("gnt_onehot", int'(gnt), 1 << mon_e.id);
          end else begin
            checkOutput("gnt_clear", int'(gnt), 0);
            checkOutput("cnt_at_event", int'(cnt), mon_e.cnt);
            checkOutput("done_abort_excl", int'(done & abort), 0);
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    int e;

    $display("[TB] start");
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // T1: reset values, then asynchronous reset in the middle of counting
    checkOutput("rst_gnt", int'(gnt), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cnt", int'(cnt), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_abort", int'(abort), 0);
    checkOutput("rst_owner", int'(owner_id), 0);
    rst_n = 1'b1;
    e = cyc;
    expectEvent(K_GNT, 0, 0, e + 1);
    applyStimulus(2'b01, 2'b01, 5);
    checkOutput("mid_busy", int'(busy), 1);
    checkOutput("mid_cnt", int'(cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_gnt", int'(gnt), 0);
    checkOutput("async_cnt", int'(cnt), 0);
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_done", int'(done), 0);
    checkOutput("async_abort", int'(abort), 0);
    req = '0;
    x   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T2: single owner, 16 continuous x pulses
    e = cyc;
    expectEvent(K_GNT, 0, 0, e + 1);
    expectEvent(K_DONE, 0, 15, e + 18);
    applyStimulus(2'b01, 2'b01, 18);
    applyStimulus(2'b00, 2'b00, 2);

    // T3: both requesting after reset -> owners 0, 1, 0
    resetDut();
    e = cyc;
    expectEvent(K_GNT, 0, 0, e + 1);
    expectEvent(K_DONE, 0, 15, e + 18);
    expectEvent(K_GNT, 1, 0, e + 20);
    expectEvent(K_DONE, 1, 15, e + 37);
    expectEvent(K_GNT, 0, 0, e + 39);
    expectEvent(K_DONE, 0, 15, e + 56);
    applyStimulus(2'b11, 2'b11, 56);
    applyStimulus(2'b00, 2'b00, 2);

    // T4: requester 1 drops req at cnt=7 while still pulsing x
    e = cyc;
    expectEvent(K_GNT, 1, 0, e + 1);
    expectEvent(K_ABORT, 1, 7, e + 10);
    applyStimulus(2'b10, 2'b10, 9);
    applyStimulus(2'b00, 2'b10, 1);
    applyStimulus(2'b00, 2'b00, 2);

    // T5: 7 idle cycles survive, one pulse, then 8 idle cycles time out
    e = cyc;
    expectEvent(K_GNT, 0, 0, e + 1);
    expectEvent(K_ABORT, 0, 4, e + 21);
    applyStimulus(2'b01, 2'b01, 5);
    applyStimulus(2'b01, 2'b00, 7);
    applyStimulus(2'b01, 2'b01, 1);
    applyStimulus(2'b01, 2'b00, 8);
    applyStimulus(2'b00, 2'b00, 2);

    // T6: non-owner x ignored, then req drops on the terminal pulse
    e = cyc;
    expectEvent(K_GNT, 0, 0, e + 1);
    expectEvent(K_DONE, 0, 15, e + 22);
    applyStimulus(2'b01, 2'b01, 2);
    applyStimulus(2'b01, 2'b10, 1);
    applyStimulus(2'b01, 2'b00, 1);
    applyStimulus(2'b01, 2'b10, 1);
    applyStimulus(2'b01, 2'b10, 1);
    checkOutput("nonowner_cnt", int'(cnt), 0);
    applyStimulus(2'b01, 2'b11, 15);
    applyStimulus(2'b00, 2'b11, 1);
    applyStimulus(2'b00, 2'b00, 3);

    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
